jk_cmd_sequencer: RTL and testbench
===================================

JK_CMD_SEQUENCER -- requirements
Module: jk_cmd_sequencer

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the command FIFO depth in entries (power of two, min 2).
REQ-002 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 cmd_valid  input  1  upstream command strobe.
REQ-005 cmd  input  2  command: 00 hold, 01 reset, 10 set, 11 toggle.
REQ-006 cmd_ready  output  1  high when a command can be accepted.
REQ-007 j  output  1  registered J drive to the downstream JK flip-flop.
REQ-008 k  output  1  registered K drive to the downstream JK flip-flop.
REQ-009 q_in  input  1  Q returned from the downstream JK flip-flop.
REQ-010 rsp_valid  output  1  one-cycle pulse per completed command.
REQ-011 rsp_q  output  1  Q captured for the completed command.
REQ-012 rsp_err  output  1  high with rsp_valid when captured Q differs from expected.
REQ-013 busy  output  1  high when state is not IDLE or the FIFO is non-empty.

Function
REQ-014 A command SHALL be accepted on an edge where cmd_valid and cmd_ready are both high; cmd_ready SHALL equal NOT full.
REQ-015 The FIFO SHALL be first-in first-out, DEPTH entries, with wrap-around pointers and an occupancy count of width log2(DEPTH)+1.
REQ-016 The FSM SHALL have states IDLE, DRIVE and CAPTURE.
REQ-017 IDLE: if the FIFO is non-empty, pop the head, load j/k from it, and go to DRIVE; otherwise stay and hold j=k=0.
REQ-018 j/k SHALL be: hold 0/0, reset 0/1, set 1/0, toggle 1/1.
REQ-019 DRIVE lasts exactly one cycle; on its closing edge q_before SHALL latch q_in, j/k SHALL return to 0/0, and the FSM SHALL enter CAPTURE.
REQ-020 The expected Q SHALL be: hold q_before, reset 0, set 1, toggle NOT q_before.
REQ-021 CAPTURE: on its closing edge, rsp_q SHALL latch q_in, rsp_err SHALL latch (q_in != expected), and rsp_valid SHALL pulse high for the following cycle.
REQ-022 From CAPTURE, if the FIFO is non-empty, the block SHALL pop and go directly to DRIVE; otherwise it SHALL go to IDLE.
REQ-023 Latency: for a command accepted at edge E0 into an empty, idle block, j/k SHALL be asserted in the cycle after E0+1, and rsp_valid SHALL be high in the cycle after E0+3.
REQ-024 Back-to-back throughput SHALL be one command per 2 cycles.
REQ-025 A push and a pop on the same edge SHALL leave the count unchanged; when the FIFO is full, the push SHALL be refused via cmd_ready=0.
REQ-026 A command pushed into an empty FIFO SHALL be poppable no earlier than the next edge; there is no same-cycle bypass.
REQ-027 rsp_valid SHALL NOT depend on any downstream ready; responses are never back-pressured.
REQ-028 rsp_q and rsp_err SHALL hold their values between pulses.

Reset
REQ-029 On an edge with rst=1, the block SHALL: set the state to IDLE, empty the FIFO, and drive j=k=0, rsp_valid=0, rsp_q=0, rsp_err=0, q_before=0 and busy=0 from the next cycle.
REQ-030 When rst=1 arrives mid-operation (DRIVE or CAPTURE), the in-flight and queued commands SHALL be discarded with no rsp_valid.
REQ-031 A cmd_valid on the same edge as rst=1 SHALL NOT be accepted.
REQ-032 cmd_ready SHALL be 1 in the cycle after reset release.

Verification
REQ-033 Single command with q_in looped from a behavioural JK FF starting at Q=0: set -> j=1,k=0 for one cycle; rsp_valid 4 cycles after accept with rsp_q=1, rsp_err=0.
REQ-034 Burst hold, reset, set, toggle, toggle: responses in order with rsp_q = 0,0,1,0,1, rsp_err=0 for all, and exactly one cycle between rsp_valid pulses.
REQ-035 Push DEPTH+1 commands with cmd_valid held high and the block stalled behind an in-flight command: cmd_ready=0 when full; the extra command is accepted only after a pop; no loss or reorder.
REQ-036 Force q_in stuck at 0 and issue a set: rsp_valid with rsp_q=0 and rsp_err=1.
REQ-037 Assert rst during DRIVE with 2 commands queued: no rsp_valid follows; j=k=0, busy=0 and cmd_ready=1 after reset.
REQ-038 Simultaneous push and pop with the FIFO at DEPTH-1: the count stays DEPTH-1 and cmd_ready stays 1.

Source files
------------

// File: rtl/jk_cmd_sequencer.sv
// jk_cmd_sequencer: queues JK commands in a small FIFO, drives a downstream JK
// flip-flop for one cycle per command, then reports the resulting Q and a mismatch flag.
module jk_cmd_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic [1:0] cmd,
    output logic       cmd_ready,
    output logic       j,
    output logic       k,
    input  logic       q_in,
    output logic       rsp_valid,
    output logic       rsp_q,
    output logic       rsp_err,
    output logic       busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRIVE   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t        state_r;
    state_t        state_s;
    logic [1:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          full_s;
    logic          empty_s;
    logic          push_s;
    logic          pop_s;
    logic [1:0]    head_s;
    logic [1:0]    cur_cmd_r;
    logic          j_s;
    logic          k_s;
    logic          j_r;
    logic          k_r;
    logic          q_before_r;
    logic          rsp_valid_r;
    logic          rsp_q_r;
    logic          rsp_err_r;

    function automatic logic [1:0] jk_decode(input logic [1:0] c);
        case (c)
            2'b00:   return 2'b00;
            2'b01:   return 2'b01;
            2'b10:   return 2'b10;
            2'b11:   return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic expected_q(input logic [1:0] c, input logic qb);
        case (c)
            2'b00:   return qb;
            2'b01:   return 1'b0;
            2'b10:   return 1'b1;
            2'b11:   return ~qb;
            default: return qb;
        endcase
    endfunction

    assign full_s    = (count_r == FULL_CNT);
    assign empty_s   = (count_r == {CW{1'b0}});
    assign push_s    = cmd_valid && !full_s && !rst;
    assign head_s    = mem_r[rd_ptr_r];
    assign cmd_ready = !full_s;
    assign busy      = (state_r != IDLE) || !empty_s;
    assign j         = j_r;
    assign k         = k_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_q     = rsp_q_r;
    assign rsp_err   = rsp_err_r;

    // FIFO storage; contents need no reset because count gates every read
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= cmd;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_r <= IDLE;
        else     state_r <= state_s;
    end

    // FSM next state; a pop happens whenever the engine is free and work is queued
    always_comb begin
        state_s = state_r;
        pop_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (!empty_s) begin
                    pop_s   = 1'b1;
                    state_s = DRIVE;
                end else begin
                    state_s = IDLE;
                end
            end
            DRIVE: begin
                state_s = CAPTURE;
            end
            CAPTURE: begin
                if (!empty_s) begin
                    pop_s   = 1'b1;
                    state_s = DRIVE;
                end else begin
                    state_s = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // FSM outputs: J/K are driven only for the cycle following a pop
    always_comb begin
        j_s = 1'b0;
        k_s = 1'b0;
        if (pop_s) begin
            {j_s, k_s} = jk_decode(head_s);
        end else begin
            {j_s, k_s} = 2'b00;
        end
    end

    // Registered drive, Q sampling and response generation
    always_ff @(posedge clk) begin
        if (rst) begin
            j_r         <= 1'b0;
            k_r         <= 1'b0;
            cur_cmd_r   <= 2'b00;
            q_before_r  <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_q_r     <= 1'b0;
            rsp_err_r   <= 1'b0;
        end else begin
            j_r         <= j_s;
            k_r         <= k_s;
            rsp_valid_r <= (state_r == CAPTURE);
            if (pop_s) cur_cmd_r <= head_s;
            if (state_r == DRIVE) q_before_r <= q_in;
            if (state_r == CAPTURE) begin
                rsp_q_r   <= q_in;
                rsp_err_r <= (q_in != expected_q(cur_cmd_r, q_before_r));
            end
        end
    end

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Self-checking bench for jk_cmd_sequencer: directed vector table, multi-cycle
// sequences and random traffic against a cycle-schedule reference model.
module tb_jk_cmd_sequencer;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd = 2'b00;
    logic       cmd_ready;
    logic       j;
    logic       k;
    logic       q_in;
    logic       rsp_valid;
    logic       rsp_q;
    logic       rsp_err;
    logic       busy;

    logic q_ff = 1'b0;
    logic preset_en = 1'b0;
    logic preset_val = 1'b0;
    logic stuck = 1'b0;
    logic chk_en = 1'b0;

    int n_checks = 0;
    int n_fail = 0;

    jk_cmd_sequencer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(cmd_ready),
        .j(j), .k(k), .q_in(q_in), .rsp_valid(rsp_valid), .rsp_q(rsp_q),
        .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural downstream JK flip-flop, optionally preset or stuck at 0
    assign q_in = stuck ? 1'b0 : q_ff;
    always @(posedge clk) begin
        if (preset_en) q_ff <= preset_val;
        else begin
            case ({j, k})
                2'b01:   q_ff <= 1'b0;
                2'b10:   q_ff <= 1'b1;
                2'b11:   q_ff <= ~q_ff;
                default: q_ff <= q_ff;
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic want_q(input logic [1:0] c, input logic qb);
        case (c)
            2'b01:   return 1'b0;
            2'b10:   return 1'b1;
            2'b11:   return ~qb;
            default: return qb;
        endcase
    endfunction

    // Reference model: a queue plus cycle-number schedule (pop at t, sample Q at t+1, respond at t+2)
    logic [1:0] mq[$];
    int   cyc = 0;
    int   m_free_at = 0;
    int   m_qb_at = -1;
    int   m_resp_at = -1;
    int   m_sz;
    logic [1:0] m_cur;
    logic m_qb, m_j, m_k, m_rv, m_rq, m_re, m_ready, m_busy;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            mq.delete();
            m_free_at = cyc; m_qb_at = -1; m_resp_at = -1;
            m_qb = 1'b0; m_j = 1'b0; m_k = 1'b0;
            m_rv = 1'b0; m_rq = 1'b0; m_re = 1'b0;
        end else begin
            m_sz = mq.size();
            m_rv = 1'b0;
            if (cyc == m_qb_at) m_qb = q_in;
            if (cyc == m_resp_at) begin
                m_rv = 1'b1;
                m_rq = q_in;
                m_re = (q_in != want_q(m_cur, m_qb));
            end
            m_j = 1'b0; m_k = 1'b0;
            if (cyc >= m_free_at && m_sz > 0) begin
                m_cur = mq.pop_front();
                case (m_cur)
                    2'b01:   begin m_j = 1'b0; m_k = 1'b1; end
                    2'b10:   begin m_j = 1'b1; m_k = 1'b0; end
                    2'b11:   begin m_j = 1'b1; m_k = 1'b1; end
                    default: begin m_j = 1'b0; m_k = 1'b0; end
                endcase
                m_qb_at = cyc + 1; m_resp_at = cyc + 2; m_free_at = cyc + 2;
            end
            if (cmd_valid && m_sz < DEPTH) mq.push_back(cmd);
        end
        m_ready = (mq.size() < DEPTH);
        m_busy  = (cyc < m_free_at) || (mq.size() > 0);
    end

    // Continuous comparison of every output against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("m_cmd_ready", cmd_ready, m_ready);
            check("m_j", j, m_j);
            check("m_k", k, m_k);
            check("m_rsp_valid", rsp_valid, m_rv);
            check("m_rsp_q", rsp_q, m_rq);
            check("m_rsp_err", rsp_err, m_re);
            check("m_busy", busy, m_busy);
        end
    end

    typedef struct {
        logic       q0;
        logic [1:0] c;
        logic       stk;
        logic       ej;
        logic       ek;
        logic       erq;
        logic       ere;
    } vec_t;
    vec_t vecs[9];

    task automatic run_vec(input int idx);
        vec_t v = vecs[idx];
        @(negedge clk); preset_en = 1'b1; preset_val = v.q0; stuck = v.stk;
        @(negedge clk); preset_en = 1'b0; cmd_valid = 1'b1; cmd = v.c;
        check($sformatf("v%0d_ready", idx), cmd_ready, 1);
        @(negedge clk); cmd_valid = 1'b0;
        @(negedge clk);
        check($sformatf("v%0d_j", idx), j, v.ej);
        check($sformatf("v%0d_k", idx), k, v.ek);
        @(negedge clk);
        check($sformatf("v%0d_jk_release", idx), {j, k}, 2'b00);
        @(negedge clk);
        check($sformatf("v%0d_rsp_valid", idx), rsp_valid, 1);
        check($sformatf("v%0d_rsp_q", idx), rsp_q, v.erq);
        check($sformatf("v%0d_rsp_err", idx), rsp_err, v.ere);
        @(negedge clk);
        check($sformatf("v%0d_pulse_end", idx), rsp_valid, 0);
        check($sformatf("v%0d_rsp_q_hold", idx), rsp_q, v.erq);
        check($sformatf("v%0d_idle", idx), busy, 0);
        stuck = 1'b0;
    endtask

    logic [1:0] seq_cmd[12];
    logic got_q[$];
    logic got_e[$];
    int   got_t[$];
    logic saw_full;

    // Push n commands with cmd_valid held until each is accepted, recording responses
    task automatic run_seq(input int n);
        int pi;
        pi = 0;
        got_q.delete(); got_e.delete(); got_t.delete();
        saw_full = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got_q.push_back(rsp_q);
                got_e.push_back(rsp_err);
                got_t.push_back(c);
            end
            if (pi < n && !cmd_ready) saw_full = 1'b1;
            cmd_valid = (pi < n);
            cmd = (pi < n) ? seq_cmd[pi] : 2'b00;
            if (pi < n && cmd_ready) pi++;
        end
        cmd_valid = 1'b0;
    endtask

    logic exp_b[5];
    int   rv_cnt;

    initial begin
        vecs[0] = '{1'b0, 2'b10, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 2'b11, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{1'b1, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[8] = '{1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

        // Reset with a command offered on the same edges: it must not be taken
        rst = 1'b1; cmd_valid = 1'b1; cmd = 2'b10;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0; cmd_valid = 1'b0;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_jk", {j, k}, 2'b00);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_q", rsp_q, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_busy", busy, 0);
        chk_en = 1'b1;

        for (int i = 0; i < 9; i++) run_vec(i);

        // Burst: hold, reset, set, toggle, toggle from Q=0
        @(negedge clk); preset_en = 1'b1; preset_val = 1'b0;
        @(negedge clk); preset_en = 1'b0;
        seq_cmd[0] = 2'b00; seq_cmd[1] = 2'b01; seq_cmd[2] = 2'b10;
        seq_cmd[3] = 2'b11; seq_cmd[4] = 2'b11;
        exp_b = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        run_seq(5);
        check("burst_count", got_q.size(), 5);
        for (int i = 0; i < 5 && i < got_q.size(); i++) begin
            check($sformatf("burst_q%0d", i), got_q[i], exp_b[i]);
            check($sformatf("burst_err%0d", i), got_e[i], 0);
            if (i > 0) check($sformatf("burst_gap%0d", i), got_t[i] - got_t[i-1], 2);
        end

        // Overfill: more commands than the FIFO holds, alternating set/reset to expose order
        for (int i = 0; i < 10; i++) seq_cmd[i] = (i % 2 == 0) ? 2'b10 : 2'b01;
        run_seq(10);
        check("full_seen", saw_full, 1);
        check("full_count", got_q.size(), 10);
        for (int i = 0; i < 10 && i < got_q.size(); i++) begin
            check($sformatf("full_q%0d", i), got_q[i], (i % 2 == 0) ? 1 : 0);
        end

        // Reset during DRIVE with two commands still queued
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); cmd_valid = 1'b1; cmd = 2'b10;
        end
        @(negedge clk);
        check("mid_drive_j", j, 1);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0; cmd_valid = 1'b0;
        check("mid_rst_jk", {j, k}, 2'b00);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", cmd_ready, 1);
        rv_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid) rv_cnt++;
            @(negedge clk);
        end
        check("mid_rst_no_rsp", rv_cnt, 0);

        // Random traffic with occasional stuck Q and resets
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 79) == 0);
            cmd_valid = ($urandom_range(0, 1) == 1);
            cmd = 2'($urandom_range(0, 3));
            stuck = ($urandom_range(0, 9) == 0);
        end
        @(negedge clk); rst = 1'b0; cmd_valid = 1'b0; stuck = 1'b0;
        repeat (30) @(negedge clk);
        check("final_idle", busy, 0);
        chk_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
